// File: rtl/cache_pipe_if.sv
// Lookup request/response types and the bundle connecting the transaction queue
// to the cache lookup pipeline, including the dirty-victim writeback outputs.
package cache_pipe_pkg;
    localparam logic [1:0] NO_LU   = 2'd0;
    localparam logic [1:0] RD_LU   = 2'd1;
    localparam logic [1:0] WR_LU   = 2'd2;
    localparam logic [1:0] FILL_LU = 2'd3;

    localparam logic [1:0] HIT    = 2'd0;
    localparam logic [1:0] MISS   = 2'd1;
    localparam logic [1:0] REJECT = 2'd2;

    typedef struct packed {
        logic         valid;
        logic [1:0]   lu_op;
        logic [31:0]  address;
        logic [127:0] cl_data;
        logic [31:0]  data;
        logic [4:0]   tq_id;
    } t_lu_req;

    typedef struct packed {
        logic         valid;
        logic [1:0]   lu_opcode;
        logic [1:0]   lu_result;
        logic [31:0]  address;
        logic [127:0] data;
        logic [4:0]   tq_id;
    } t_lu_rsp;
endpackage

interface cache_pipe_if;
    import cache_pipe_pkg::*;

    t_lu_req      pipe_lu_req_q1;
    t_lu_rsp      pipe_lu_rsp_q3;
    logic         evict_valid;
    logic [31:0]  evict_address;
    logic [127:0] evict_data;

    modport master (
        output pipe_lu_req_q1,
        input  pipe_lu_rsp_q3,
        input  evict_valid,
        input  evict_address,
        input  evict_data
    );

    modport slave (
        input  pipe_lu_req_q1,
        output pipe_lu_rsp_q3,
        output evict_valid,
        output evict_address,
        output evict_data
    );
endinterface

// File: rtl/cache_pipe.sv
// Three-stage direct-mapped write-back cache lookup: q1 capture, q2 compare and
// array access, q3 registered response plus dirty-victim eviction pulse.
module cache_pipe
    import cache_pipe_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int ADDR_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    cache_pipe_if.slave    lu
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - 4 - SET_W;

    t_lu_req               req_q, req_d;
    t_lu_rsp               rsp_q, rsp_d;
    logic                  evict_valid_q, evict_valid_d;
    logic [ADDR_W-1:0]     evict_address_q, evict_address_d;
    logic [127:0]          evict_data_q, evict_data_d;

    logic [NUM_SETS-1:0]   valid_q;
    logic [NUM_SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [127:0]          line_q [NUM_SETS];

    logic [SET_W-1:0]      set_s;
    logic [TAG_W-1:0]      tag_s;
    logic [1:0]            word_s;
    logic                  hit_s;
    logic [127:0]          old_line_s;
    logic [127:0]          wr_line_s;
    logic [127:0]          new_line_s;
    logic                  new_dirty_s;
    logic                  arr_we_s;
    logic                  unused_s;

    assign set_s      = req_q.address[3+SET_W:4];
    assign tag_s      = req_q.address[ADDR_W-1:4+SET_W];
    assign word_s     = req_q.address[3:2];
    assign old_line_s = line_q[set_s];
    assign hit_s      = valid_q[set_s] && (tag_q[set_s] == tag_s);
    assign unused_s   = ^req_q.address[1:0];

    // Non-valid q1 slots enter q2 as all-zero bubbles.
    always_comb begin
        if (lu.pipe_lu_req_q1.valid) begin
            req_d = lu.pipe_lu_req_q1;
        end else begin
            req_d = '0;
        end
    end

    // q2 lookup: decide response, array update and any dirty-victim eviction.
    always_comb begin
        rsp_d           = '0;
        evict_valid_d   = 1'b0;
        evict_address_d = '0;
        evict_data_d    = '0;
        arr_we_s        = 1'b0;
        new_line_s      = old_line_s;
        new_dirty_s     = dirty_q[set_s];
        wr_line_s       = old_line_s;
        wr_line_s[{word_s, 5'd0} +: 32] = req_q.data;
        if (req_q.valid) begin
            rsp_d.valid     = 1'b1;
            rsp_d.lu_opcode = req_q.lu_op;
            rsp_d.address   = req_q.address;
            rsp_d.tq_id     = req_q.tq_id;
            case (req_q.lu_op)
                RD_LU: begin
                    if (hit_s) begin
                        rsp_d.lu_result = HIT;
                        rsp_d.data      = old_line_s;
                    end else begin
                        rsp_d.lu_result = MISS;
                    end
                end
                WR_LU: begin
                    if (hit_s) begin
                        rsp_d.lu_result = HIT;
                        rsp_d.data      = wr_line_s;
                        arr_we_s        = 1'b1;
                        new_line_s      = wr_line_s;
                        new_dirty_s     = 1'b1;
                    end else begin
                        rsp_d.lu_result = MISS;
                    end
                end
                FILL_LU: begin
                    rsp_d.lu_result = HIT;
                    rsp_d.data      = req_q.cl_data;
                    arr_we_s        = 1'b1;
                    new_line_s      = req_q.cl_data;
                    new_dirty_s     = 1'b0;
                    // A fill over the same tag simply refreshes the line.
                    if (valid_q[set_s] && dirty_q[set_s] && (tag_q[set_s] != tag_s)) begin
                        evict_valid_d   = 1'b1;
                        evict_address_d = {tag_q[set_s], set_s, 4'b0000};
                        evict_data_d    = old_line_s;
                    end else begin
                        evict_valid_d   = 1'b0;
                    end
                end
                default: begin
                    rsp_d.lu_result = REJECT;
                end
            endcase
        end else begin
            rsp_d = '0;
        end
    end

    // Pipeline registers for q2 request and q3 response/eviction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q           <= '0;
            rsp_q           <= '0;
            evict_valid_q   <= 1'b0;
            evict_address_q <= '0;
            evict_data_q    <= '0;
        end else begin
            req_q           <= req_d;
            rsp_q           <= rsp_d;
            evict_valid_q   <= evict_valid_d;
            evict_address_q <= evict_address_d;
            evict_data_q    <= evict_data_d;
        end
    end

    // Tag/valid/dirty/data arrays, updated at the q2->q3 edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else if (arr_we_s) begin
            valid_q[set_s] <= 1'b1;
            dirty_q[set_s] <= new_dirty_s;
            tag_q[set_s]   <= tag_s;
            line_q[set_s]  <= new_line_s;
        end
    end

    assign lu.pipe_lu_rsp_q3 = rsp_q;
    assign lu.evict_valid    = evict_valid_q;
    assign lu.evict_address  = evict_address_q;
    assign lu.evict_data     = evict_data_q;
endmodule

// File: tb/tb_cache_pipe.sv
// Self-checking bench for cache_pipe: directed scenarios plus random traffic
// checked against an array-based cache model kept in the bench.
module tb_cache_pipe;
    import cache_pipe_pkg::*;

    typedef struct packed {
        t_lu_rsp      rsp;
        logic         ev_v;
        logic [31:0]  ev_a;
        logic [127:0] ev_d;
    } t_obs;

    logic clk;
    logic rst;
    cache_pipe_if lu_if ();

    cache_pipe dut (
        .clk (clk),
        .rst (rst),
        .lu  (lu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural cache model
    logic         m_valid [16];
    logic         m_dirty [16];
    int unsigned  m_tag   [16];
    logic [127:0] m_line  [16];

    t_obs pipe0, pipe1, exp_now, got;
    t_obs seen [64];

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_W = 128'h44444444_33333333_DEADBEEF_11111111;
    localparam logic [127:0] LINE_B = 128'h88888888_77777777_66666666_55555555;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
            m_line[i]  = '0;
        end
        pipe0 = '0;
        pipe1 = '0;
    endtask

    task automatic model_step(input t_lu_req r, output t_obs e);
        int unsigned a, s, tg, w;
        logic        hit;
        logic [127:0] line;
        e   = '0;
        a   = r.address;
        s   = (a / 16) % 16;
        tg  = a / 256;
        w   = (a / 4) % 4;
        hit = m_valid[s] && (m_tag[s] == tg);
        if (r.valid) begin
            e.rsp.valid     = 1'b1;
            e.rsp.lu_opcode = r.lu_op;
            e.rsp.address   = r.address;
            e.rsp.tq_id     = r.tq_id;
            if (r.lu_op == RD_LU) begin
                e.rsp.lu_result = hit ? HIT : MISS;
                e.rsp.data      = hit ? m_line[s] : 128'd0;
            end else if (r.lu_op == WR_LU) begin
                e.rsp.lu_result = hit ? HIT : MISS;
                if (hit) begin
                    line = m_line[s];
                    line[w*32 +: 32] = r.data;
                    m_line[s]  = line;
                    m_dirty[s] = 1'b1;
                    e.rsp.data = line;
                end
            end else if (r.lu_op == FILL_LU) begin
                e.rsp.lu_result = HIT;
                e.rsp.data      = r.cl_data;
                if (m_valid[s] && m_dirty[s] && m_tag[s] != tg) begin
                    e.ev_v = 1'b1;
                    e.ev_a = m_tag[s] * 256 + s * 16;
                    e.ev_d = m_line[s];
                end
                m_valid[s] = 1'b1;
                m_dirty[s] = 1'b0;
                m_tag[s]   = tg;
                m_line[s]  = r.cl_data;
            end else begin
                e.rsp.lu_result = REJECT;
            end
        end
    endtask

    function automatic t_lu_req mk(input logic [1:0] op, input logic [31:0] addr,
                                   input logic [127:0] cl, input logic [31:0] d,
                                   input logic [4:0] id);
        t_lu_req r;
        r.valid   = 1'b1;
        r.lu_op   = op;
        r.address = addr;
        r.cl_data = cl;
        r.data    = d;
        r.tq_id   = id;
        return r;
    endfunction

    function automatic t_obs outs();
        return {lu_if.pipe_lu_rsp_q3, lu_if.evict_valid, lu_if.evict_address, lu_if.evict_data};
    endfunction

    // Sample outputs at the negedge, advance expected pipeline, then drive.
    task automatic cycle(input t_lu_req r);
        t_obs e;
        @(negedge clk);
        got     = outs();
        exp_now = pipe1;
        pipe1   = pipe0;
        model_step(r, e);
        pipe0   = e;
        lu_if.pipe_lu_req_q1 = r;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        lu_if.pipe_lu_req_q1 = '0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== t_obs'(0)) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", outs());
        end
        rst = 1'b1;
    endtask

    task automatic run_seq(input string name, input t_lu_req reqs[$]);
        int n;
        t_lu_req b;
        b = '0;
        n = reqs.size();
        for (int i = 0; i < n + 2; i++) begin
            cycle(i < n ? reqs[i] : b);
            seen[i] = got;
            checks++;
            if (got !== exp_now) begin
                errors++;
                $display("FAIL %s[%0d] got=%h exp=%h", name, i, got, exp_now);
            end
        end
        cycle(b);
        seen[n+2] = got;
        checks++;
        if (got !== exp_now) begin
            errors++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, n + 2, got, exp_now);
        end
    endtask

    task automatic test_read_miss();
        t_lu_req q[$];
        q.push_back(mk(RD_LU, 32'h0000_0040, 128'd0, 32'd0, 5'd3));
        run_seq("read_miss", q);
        checks++;
        if (!(seen[2].rsp.valid === 1'b1 && seen[2].rsp.lu_result === MISS &&
              seen[2].rsp.data === 128'd0 && seen[2].rsp.tq_id === 5'd3)) begin
            errors++;
            $display("FAIL read_miss_latency got=%h exp=valid MISS tq3", seen[2].rsp);
        end
    endtask

    task automatic test_fill_read();
        t_lu_req q[$];
        q.push_back(mk(FILL_LU, 32'h0000_0040, LINE_A, 32'd0, 5'd1));
        q.push_back(mk(RD_LU, 32'h0000_0048, 128'd0, 32'd0, 5'd2));
        run_seq("fill_read", q);
        checks++;
        if (seen[3].rsp.data[95:64] !== 32'h33333333 || seen[3].rsp.lu_result !== HIT ||
            seen[2].ev_v !== 1'b0) begin
            errors++;
            $display("FAIL fill_read_word2 got=%h exp=33333333", seen[3].rsp.data[95:64]);
        end
    endtask

    task automatic test_write_hit();
        t_lu_req q[$];
        q.push_back(mk(WR_LU, 32'h0000_0044, 128'd0, 32'hDEADBEEF, 5'd4));
        q.push_back(mk(RD_LU, 32'h0000_0040, 128'd0, 32'd0, 5'd5));
        run_seq("write_hit", q);
        checks++;
        if (seen[3].rsp.data !== LINE_W || seen[2].rsp.lu_result !== HIT) begin
            errors++;
            $display("FAIL write_hit_line got=%h exp=%h", seen[3].rsp.data, LINE_W);
        end
    endtask

    task automatic test_evict();
        t_lu_req q[$];
        q.push_back(mk(FILL_LU, 32'h0000_0440, LINE_B, 32'd0, 5'd6));
        q.push_back(mk(RD_LU, 32'h0000_0040, 128'd0, 32'd0, 5'd8));
        run_seq("evict", q);
        checks++;
        if (seen[2].ev_v !== 1'b1 || seen[2].ev_a !== 32'h0000_0040 || seen[2].ev_d !== LINE_W ||
            seen[3].ev_v !== 1'b0 || seen[3].rsp.lu_result !== MISS) begin
            errors++;
            $display("FAIL evict_pulse got=%b/%h/%h exp=1/00000040/%h",
                     seen[2].ev_v, seen[2].ev_a, seen[2].ev_d, LINE_W);
        end
    endtask

    task automatic test_reject_write_miss();
        t_lu_req q[$];
        q.push_back(mk(NO_LU, 32'h0000_0100, 128'd0, 32'd0, 5'd7));
        q.push_back(mk(WR_LU, 32'h0000_1230, 128'd0, 32'h12345678, 5'd9));
        q.push_back(mk(RD_LU, 32'h0000_1230, 128'd0, 32'd0, 5'd10));
        run_seq("reject_wmiss", q);
        checks++;
        if (seen[2].rsp.lu_result !== REJECT || seen[2].rsp.tq_id !== 5'd7 ||
            seen[3].rsp.lu_result !== MISS || seen[4].rsp.lu_result !== MISS ||
            seen[4].rsp.data !== 128'd0) begin
            errors++;
            $display("FAIL reject_wmiss got=%h/%h exp=REJECT/MISS", seen[2].rsp.lu_result,
                     seen[4].rsp.lu_result);
        end
    endtask

    task automatic test_random();
        t_lu_req r;
        for (int i = 0; i < 400; i++) begin
            r.valid   = ($urandom_range(0, 7) != 0);
            r.lu_op   = 2'($urandom_range(0, 3));
            r.address = ($urandom_range(0, 2) * 256) + ($urandom_range(0, 3) * 16) + ($urandom_range(0, 15));
            r.cl_data = {$urandom, $urandom, $urandom, $urandom};
            r.data    = $urandom;
            r.tq_id   = 5'($urandom_range(0, 31));
            if (!r.valid) r = '0;
            cycle(r);
            checks++;
            if (got !== exp_now) begin
                errors++;
                $display("FAIL random[%0d] got=%h exp=%h", i, got, exp_now);
            end
        end
    endtask

    task automatic test_reset_midstream();
        t_lu_req q[$];
        t_lu_req b;
        b = '0;
        q.push_back(mk(FILL_LU, 32'h0000_0080, LINE_A, 32'd0, 5'd11));
        run_seq("pre_reset", q);
        cycle(mk(RD_LU, 32'h0000_0080, 128'd0, 32'd0, 5'd12));
        cycle(mk(RD_LU, 32'h0000_0440, 128'd0, 32'd0, 5'd13));
        cycle(mk(RD_LU, 32'h0000_0084, 128'd0, 32'd0, 5'd14));
        checks++;
        if (got !== exp_now) begin
            errors++;
            $display("FAIL midreset_first got=%h exp=%h", got, exp_now);
        end
        rst = 1'b0;
        #1;
        model_clear();
        checks++;
        if (outs() !== t_obs'(0)) begin
            errors++;
            $display("FAIL reset_async got=%h exp=0", outs());
        end
        @(negedge clk);
        checks++;
        if (outs() !== t_obs'(0)) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", outs());
        end
        rst = 1'b1;
        lu_if.pipe_lu_req_q1 = b;
        q.delete();
        q.push_back(mk(RD_LU, 32'h0000_0080, 128'd0, 32'd0, 5'd15));
        q.push_back(mk(RD_LU, 32'h0000_0440, 128'd0, 32'd0, 5'd16));
        run_seq("post_reset", q);
        checks++;
        if (seen[0].rsp.valid !== 1'b0 || seen[1].rsp.valid !== 1'b0 ||
            seen[2].rsp.lu_result !== MISS || seen[3].rsp.lu_result !== MISS) begin
            errors++;
            $display("FAIL post_reset_miss got=%h/%h exp=MISS/MISS", seen[2].rsp.lu_result,
                     seen[3].rsp.lu_result);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_fill_read();
        test_write_hit();
        test_evict();
        test_reject_write_miss();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cache_pipe.md
Name: cache_pipe

Overview:
- Cache lookup pipeline sitting directly downstream of the cache transaction queue.
- Accepts one lookup request per cycle on the q1 interface. Performs the tag/valid compare and the data-array read or write at q2. Returns a registered response at q3.
- Direct-mapped, write-back array held in flops.
- Emits a dirty-line eviction when a fill replaces a modified line.

Parameters:
- NUM_SETS, 16, number of direct-mapped sets (power of 2); SET_W = log2(NUM_SETS).
- ADDR_W, 32, byte address width; line = 16 B, so offset is [3:0] and the word index is [3:2].
- TAG_W, ADDR_W-4-SET_W, tag field = address[ADDR_W-1:4+SET_W].

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- pipe_lu_req_q1  input  t_lu_req  fields:
  - valid 1
  - lu_op 2 (NO_LU/RD_LU/WR_LU/FILL_LU)
  - address 32
  - cl_data 128
  - data 32
  - tq_id 5
- pipe_lu_rsp_q3  output  t_lu_rsp  fields:
  - valid 1
  - lu_opcode 2
  - lu_result 2 (HIT/MISS/REJECT)
  - address 32
  - data 128
  - tq_id 5
- evict_valid  output  1  dirty victim written back this cycle.
- evict_address  output  32  {victim tag, set, 4'b0}.
- evict_data  output  128  victim cacheline.

Behaviour:
- Reset (rst=0, async): all q2/q3 pipeline registers cleared; pipe_lu_rsp_q3 all fields 0; evict_* = 0; every set's valid, dirty, tag and data cleared to 0.
- Pipeline:
  - Edge 1: q1 request (valid=1) is captured into the q2 register.
  - q2 cycle: arrays read combinationally at set = address[3+SET_W:4]. hit = valid[set] && tag[set]==q2 tag.
  - Edge 2: result captured into the q3 register, and the array update for the q2 op is written at the same edge.
- Latency: request valid in cycle N → pipe_lu_rsp_q3.valid in cycle N+2. Throughput is 1/cycle, with no stall and no backpressure.
- Back-to-back requests to the same set need no forwarding. The array write at edge 2 of request A is visible to request B in its q2 cycle.
- Response fields address, tag id and opcode are copied unchanged from the request.
- RD_LU:
  - hit → lu_result=HIT, data = stored line.
  - miss → MISS, data=0.
  - No array change either way.
- WR_LU:
  - hit → lu_result=HIT. Word address[3:2] of the line is replaced by request data; the other 3 words are unchanged; dirty[set]=1; data = updated line.
  - miss → MISS, data=0, no array change (no write-allocate).
- FILL_LU:
  - Always writes tag, data=cl_data, valid=1, dirty=0.
  - lu_result=HIT, data=cl_data.
  - If the old line had valid=1 && dirty=1 && old tag differs from the new tag: evict_valid=1 in the same q3 cycle, evict_address = {old tag, set, 4'b0}, evict_data = old line.
  - A fill whose tag matches the resident dirty line overwrites it with no eviction.
- valid with lu_op=NO_LU → lu_result=REJECT, data=0, no array change.
- q1 valid=0 → bubble. q3 valid=0 the following cycle after next; non-valid response fields are 0.
- evict_* is a single-cycle pulse aligned with the fill's q3 response; 0 otherwise.
- Reset asserted mid-operation: in-flight q2/q3 requests are discarded with no response, and arrays are cleared.

Test Plan:
- Reset, then RD_LU addr 0x0000_0040 tq_id 3 in cycle 1 → cycle 3 rsp valid, MISS, data 0, tq_id 3.
- FILL_LU addr 0x40, cl_data 0x44444444_33333333_22222222_11111111, then RD_LU addr 0x48 next cycle → fill rsp HIT; read rsp HIT with the same line, word-2 value 0x33333333; no eviction.
- After that fill, WR_LU addr 0x44 data 0xDEADBEEF immediately followed by RD_LU 0x40 → write HIT; read returns line with [63:32]=0xDEADBEEF, other words unchanged.
- FILL_LU addr 0x440 (same set 4, different tag) after the dirty write → fill HIT, evict_valid=1 one cycle, evict_address=0x0000_0040, evict_data = the modified line; RD_LU 0x40 then MISS.
- valid request with lu_op=NO_LU, tq_id 7 → rsp valid, REJECT, data 0; WR_LU to invalid set → MISS, a later RD shows no change.
- Stream 3 requests back-to-back, assert rst for one cycle after the 2nd → no responses for requests in flight, arrays read MISS afterwards, outputs 0 during reset.
